// File: rtl/boton_reader_if.sv
// Read-side bus for boton_reader: read strobe, snapshot, valid pulse and level interrupt.
// Carries no clock. Timing is set by the module that drives the slave side.
// There is no backpressure: a read strobe is accepted on every cycle it is asserted.
interface boton_reader_if;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       irq;

  modport master (output rd_en, input rd_data, input rd_valid, input irq);
  modport slave  (input rd_en, output rd_data, output rd_valid, output irq);
endinterface

// File: rtl/boton_reader.sv
// Two-button reader: sync + debounce + sticky clear-on-read press flags, release flags under BOTON_RELEASE_EVT_EN.
// Latency: stable pad -> level/press at +DEBOUNCE_CYCLES+2 edges; snapshot one cycle after rd_en; irq one cycle after flag.
// No backpressure: every rd_en cycle is a read; an event that coincides with a read wins over the clear.
module boton_reader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          b1,
  input  logic          b2,
  boton_reader_if.slave bus
);

  typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       pad;
  logic [1:0]       s1;
  logic [1:0]       s2;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       level;
  logic [1:0]       press_pls;
  logic [1:0]       press_evt_q;
  logic [1:0]       press_evt_d;
  logic [1:0]       ovf_q;
  logic [1:0]       ovf_d;
  logic [1:0]       rel_evt_q;
  logic [1:0]       rd_mask;

  assign pad     = {b2, b1};
  assign rd_mask = {2{bus.rd_en}};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1 <= pad;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef BOTON_RELEASE_EVT_EN
  logic [1:0] rel_pls;
`endif

  // Any sample that disagrees with the pending level sends the channel back to its settled state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_pls[i] = 1'b0;
`ifdef BOTON_RELEASE_EVT_EN
      rel_pls[i]   = 1'b0;
`endif
      case (state_q[i])
        REL: begin
          if (s2[i]) begin
            state_d[i] = WAIT_P;
            cnt_d[i]   = '0;
          end
        end
        WAIT_P: begin
          if (!s2[i]) begin
            state_d[i] = REL;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = PRS;
            press_pls[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRS: begin
          if (!s2[i]) begin
            state_d[i] = WAIT_R;
            cnt_d[i]   = '0;
          end
        end
        WAIT_R: begin
          if (s2[i]) begin
            state_d[i] = PRS;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = REL;
`ifdef BOTON_RELEASE_EVT_EN
            rel_pls[i] = 1'b1;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level[i] = (state_q[i] == PRS) || (state_q[i] == WAIT_R);
    end
  end

  // A read reports the old flag, so a coinciding second press is not an overflow.
  assign press_evt_d = (press_evt_q & ~rd_mask) | press_pls;
  assign ovf_d       = (ovf_q | (press_pls & press_evt_q)) & ~rd_mask;

`ifdef BOTON_RELEASE_EVT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rel_evt_q <= 2'b00;
    end else begin
      rel_evt_q <= (rel_evt_q & ~rd_mask) | rel_pls;
    end
  end
`else
  assign rel_evt_q = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      press_evt_q  <= 2'b00;
      ovf_q        <= 2'b00;
      bus.rd_data  <= 8'h00;
      bus.rd_valid <= 1'b0;
      bus.irq      <= 1'b0;
    end else begin
      press_evt_q  <= press_evt_d;
      ovf_q        <= ovf_d;
      bus.rd_valid <= bus.rd_en;
      bus.irq      <= |{press_evt_q, rel_evt_q};
      if (bus.rd_en) begin
        bus.rd_data <= {rel_evt_q, ovf_q, press_evt_q, level};
      end
    end
  end

endmodule

// File: tb/tb_boton_reader.sv
// Randomised + directed bench for boton_reader with a run-length debounce model and an output scoreboard.
// Expected outputs are queued per clock edge; an independent monitor compares them on the falling edge.
module tb_boton_reader;

  localparam int DEB = 4;
`ifdef BOTON_RELEASE_EVT_EN
  localparam bit RELEN = 1'b1;
`else
  localparam bit RELEN = 1'b0;
`endif

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    logic       irq;
  } exp_t;

  logic clk;
  logic rst;
  logic b1;
  logic b2;
  boton_reader_if bus ();

  boton_reader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .b1  (b1),
    .b2  (b2),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Reference model: pad delay line, run length of samples disagreeing with the level, sticky flags.
  logic [1:0] m_s1, m_s2, m_lvl, m_pe, m_ov, m_re;
  int         m_run [2];
  logic [7:0] m_rdd;
  logic       m_rdv, m_irq;
  logic       cb1, cb2;

  function automatic exp_t model_edge(input logic v1, input logic v2, input logic rd, input logic r);
    exp_t       e;
    logic [1:0] pp, rp, nl;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pe = 0; m_ov = 0; m_re = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_rdd = 0; m_rdv = 0; m_irq = 0;
    end else begin
      pp = 0; rp = 0; nl = m_lvl;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_s2[ch] != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB + 1) begin
            nl[ch]    = ~m_lvl[ch];
            m_run[ch] = 0;
            if (nl[ch]) pp[ch] = 1'b1;
            else        rp[ch] = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_irq = (|m_pe) | (RELEN & (|m_re));
      m_rdv = rd;
      if (rd) m_rdd = {m_re, m_ov, m_pe, m_lvl};
      m_ov  = rd ? 2'b00 : (m_ov | (pp & m_pe));
      m_pe  = (rd ? 2'b00 : m_pe) | pp;
      m_re  = RELEN ? ((rd ? 2'b00 : m_re) | rp) : 2'b00;
      m_lvl = nl;
      m_s2  = m_s1;
      m_s1  = {v2, v1};
    end
    e.vld = m_rdv;
    e.dat = m_rdd;
    e.irq = m_irq;
    return e;
  endfunction

  task automatic step(input logic v1, input logic v2, input logic rd, input logic r);
    exp_t e;
    @(negedge clk);
    b1 = v1; b2 = v2; bus.rd_en = rd; rst = r;
    cb1 = v1; cb2 = v2;
    e = model_edge(v1, v2, rd, r);
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v1, input logic v2, input int n);
    for (int k = 0; k < n; k++) step(v1, v2, 1'b0, 1'b0);
  endtask

  task automatic rd_once();
    step(cb1, cb2, 1'b1, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_valid", {7'b0, bus.rd_valid}, {7'b0, e.vld});
        check("rd_data",  bus.rd_data, e.dat);
        check("irq",      {7'b0, bus.irq}, {7'b0, e.irq});
      end
    end
  end

  initial begin
    b1 = 0; b2 = 0; rst = 1; bus.rd_en = 0; cb1 = 0; cb2 = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    hold(0, 0, 3);

    // Clean press on b1, read, read again, release
    hold(1, 0, 8); rd_once(); hold(1, 0, 3); rd_once();
    hold(0, 0, 8); rd_once(); hold(0, 0, 2);

    // Glitch shorter than debounce
    hold(1, 0, 3); hold(0, 0, 8); rd_once(); hold(0, 0, 2);

    // Two b2 presses without a read: overflow
    hold(0, 1, 8); hold(0, 0, 8); hold(0, 1, 8); rd_once(); rd_once(); hold(0, 1, 2);

    // Press pulse coincides with read
    hold(0, 0, 8); rd_once(); hold(1, 0, 6); step(1, 0, 1, 0); hold(1, 0, 2); rd_once();

    // Reset during WAIT_P on b2, b2 kept high
    hold(0, 0, 8); rd_once(); hold(0, 1, 4); step(0, 1, 0, 1); hold(0, 1, 10); rd_once();

    // Press then release b1, then read
    hold(0, 0, 8); rd_once(); rd_once(); hold(1, 0, 8); hold(0, 0, 8); rd_once(); hold(0, 0, 3);

    // Simultaneous presses, read held high
    hold(1, 1, 7); step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0); hold(1, 1, 2);

    // Random bouncy pads, random reads and occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      logic v1, v2, rd, r;
      int   len;
      v1  = ($urandom_range(0, 3) == 0) ? ~cb1 : cb1;
      v2  = ($urandom_range(0, 3) == 0) ? ~cb2 : cb2;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 12);
      for (int k = 0; k < len; k++) begin
        rd = ($urandom_range(0, 5) == 0);
        r  = ($urandom_range(0, 299) == 0);
        step(v1, v2, rd, r);
      end
    end
    hold(0, 0, 10); rd_once(); rd_once();

    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boton_reader.md
Name: boton_reader

Overview:
- Bus-side reader for the two user pushbuttons. Takes raw pads b1/b2, synchronises and debounces each one, and captures press events in sticky flags.
- The CPU/peripheral side reads a snapshot with a single-cycle read strobe. The read clears the reported events (clear-on-read) and drives a level interrupt.
- Sits between the pad-level button inputs and the SoC register/CSR bus.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised samples needed to accept a new level (1 ms at 50 MHz). Legal range 2..2^CNT_W-1.
- CNT_W, 16: width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- b1  input  1  raw button 1 pad, asynchronous, active-high (pressed=1)
- b2  input  1  raw button 2 pad, asynchronous, active-high
- rd_en  input  1  read strobe, one cycle per read
- rd_data  output  8  registered read snapshot; bit map below
- rd_valid  output  1  one-cycle pulse, cycle after rd_en; rd_data valid while high and held until next read
- irq  output  1  registered; high while any press (or release, if enabled) event flag is set

Behaviour:
- Reset: synchronous, active-high; clk and rst as the single clock and reset. On rst=1 at a rising edge:
  - rd_data=0, rd_valid=0, irq=0
  - synchronisers=0, counters=0, all event/overflow flags=0
  - both channel FSMs go to REL
  - any debounce in progress is abandoned
- Synchroniser: per channel, two flops (s1->s2). The FSM sees only s2.
- Per-channel FSM, states REL, WAIT_P, PRS, WAIT_R:
  - REL: s2=1 -> WAIT_P, cnt<=0.
  - WAIT_P:
    - s2=0 -> REL (glitch rejected, no event).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRS, press pulse.
    - otherwise cnt<=cnt+1.
  - PRS: s2=0 -> WAIT_R, cnt<=0.
  - WAIT_R:
    - s2=1 -> PRS.
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> REL, release pulse.
    - otherwise cnt<=cnt+1.
  - level[i]=1 in PRS and WAIT_R, 0 in REL and WAIT_P.
- Latency: pad held stable from sampling edge E0 -> level/press pulse updates at edge E0+DEBOUNCE_CYCLES+2. Any bounce restarts the count.
- Event capture:
  - Press pulse sets press_evt[i].
  - Press pulse while press_evt[i] is already set -> ovf[i]<=1; press_evt stays 1.
- Read handshake: rd_en=1 at edge N:
  - rd_data captures {rel_evt[1:0], ovf[1:0], press_evt[1:0], level[1:0]} as they are before edge N.
  - rd_valid=1 for the cycle after edge N.
  - Flags reported as 1 in the snapshot are cleared at edge N.
- Simultaneous rd_en and new event on the same channel in the same cycle:
  - The event is not in the snapshot; its flag ends set (set wins over clear).
  - ovf is not set by this case.
- Back-to-back rd_en: each cycle gets its own snapshot and rd_valid pulse; the second read sees flags cleared by the first.
- rd_en held high: treated as a read every cycle.
- irq: registered OR of press_evt (and rel_evt when enabled); falls the cycle after the clearing read.
- rd_data bit map:
  - [1:0] debounced level {b2,b1}
  - [3:2] press_evt
  - [5:4] ovf
  - [7:6] rel_evt
- Channels are fully independent; simultaneous presses set both flags in the same cycle.

Optional Feature:
- Macro BOTON_RELEASE_EVT_EN.
- Defined:
  - Release pulses set rel_evt[i], with the same set-wins and clear-on-read rules as press_evt.
  - rel_evt contributes to irq.
  - A release while rel_evt[i] is already set does not affect ovf.
- Undefined:
  - rel_evt logic is not built; rd_data[7:6] reads 0.
  - Releases produce no flag and no irq.
  - The FSM still tracks release so that level is correct.

Test Plan:
- DEBOUNCE_CYCLES=4; rst, then b1 0->1 held -> level bit0=1 and press_evt[0]=1 at edge E0+6; irq=1 one cycle later; rd_en -> rd_data=8'h05, rd_valid pulse, irq=0 next cycle.
- b1 high 3 cycles then low (shorter than debounce) -> no level change, no event, irq stays 0; a following rd_en returns 8'h00.
- Two b2 presses with no read between -> rd_en returns 8'h2A (level=1 if still held, press_evt[1], ovf[1]); second rd_en returns 8'h02.
- Press pulse on b1 in the same cycle as rd_en -> snapshot shows press_evt[0]=0; next read shows press_evt[0]=1.
- rst asserted mid-WAIT_P on b2 while b2 stays high -> all outputs 0 the next cycle; debounce restarts from REL, giving level=1 DEBOUNCE_CYCLES+2 edges after reset release.
- BOTON_RELEASE_EVT_EN defined: press then release b1, then rd_en -> rd_data=8'h44 and irq clears; with macro undefined the same sequence gives 8'h04.
